// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - sequential stereo mixer with per-channel and master volume
//
// Purpose: on every toggle of the output sample clock, wait LATCH_DELAY cycles,
// accumulate CHANNELS volume-scaled stereo samples (one channel per cycle),
// apply master volume, saturate to 16 bits and present the result for one
// valid pulse. The result is held until the next mix completes.
//
// Optional feature macro: AUDIO_MIXER_CLIP_COUNT_EN (saturating clip counter).
//
// Ports:
//   i_clock                 system clock
//   i_reset                 asynchronous active-high reset
//   i_output_sample_clock   sample clock; either edge starts a mix
//   i_channel_left/right    16-bit signed samples, channel n at [16n+15:16n]
//   i_channel_volume        4-bit volume per channel, channel n at [4n+3:4n]
//   i_master_volume         4-bit master volume
//   o_sample_left/right     mixed 16-bit signed samples (held)
//   o_sample_valid          one-cycle pulse when o_sample_* update
//   o_clip                  pulse with o_sample_valid if either side saturated
//   i_clip_count_clear      (AUDIO_MIXER_CLIP_COUNT_EN) zero the clip counter
//   o_clip_count            (AUDIO_MIXER_CLIP_COUNT_EN) saturating clip count
//   o_overrun               pulse when a toggle is dropped during a mix
module audio_mixer #(
  parameter int CHANNELS    = 4,
  parameter int LATCH_DELAY = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_output_sample_clock,
  input  logic [16*CHANNELS-1:0]  i_channel_left,
  input  logic [16*CHANNELS-1:0]  i_channel_right,
  input  logic [4*CHANNELS-1:0]   i_channel_volume,
  input  logic [3:0]              i_master_volume,
  output logic [15:0]             o_sample_left,
  output logic [15:0]             o_sample_right,
  output logic                    o_sample_valid,
  output logic                    o_clip,
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  input  logic                    i_clip_count_clear,
  output logic [15:0]             o_clip_count,
`endif
  output logic                    o_overrun
);

  localparam int ACC_W = 17 + $clog2(CHANNELS);
  localparam int PW    = ACC_W + 5;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (LATCH_DELAY > 1) ? $clog2(LATCH_DELAY + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_MASTER = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  // Volume 15 is exact unity rather than 15/16; 0 mutes; otherwise x*v/16
  // with an arithmetic shift (rounds toward -inf).
  function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] x,
                                                    input logic [3:0] v);
    logic signed [PW-1:0] ve;
    logic signed [PW-1:0] p;
    ve = PW'($signed({1'b0, v}));
    p  = PW'(x) * ve;
    p  = p >>> 4;
    if (v == 4'd15)     return x;
    else if (v == 4'd0) return '0;
    else                return p[ACC_W-1:0];
  endfunction

  // Returns {clip, value}.
  function automatic logic [16:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return {1'b1, 16'h7FFF};
    else if (a < SAT_MIN) return {1'b1, 16'h8000};
    else                  return {1'b0, a[15:0]};
  endfunction

  logic [2:0]              state_q, state_d;
  logic                    last_clk_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [15:0]             sat_l_q, sat_l_d, sat_r_q, sat_r_d;
  logic                    clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic [15:0]             out_l_q, out_l_d, out_r_q, out_r_d;
  logic                    valid_q, valid_d, clip_q, clip_d, overrun_q, overrun_d;

  logic                    toggle;
  logic signed [15:0]      ch_l, ch_r;
  logic [3:0]              ch_vol;
  logic [16:0]             res_l, res_r;

  always_comb begin
    toggle    = (i_output_sample_clock != last_clk_q);
    ch_l      = i_channel_left[int'(idx_q)*16 +: 16];
    ch_r      = i_channel_right[int'(idx_q)*16 +: 16];
    ch_vol    = i_channel_volume[int'(idx_q)*4 +: 4];
    res_l     = saturate(scale(acc_l_q, i_master_volume));
    res_r     = saturate(scale(acc_r_q, i_master_volume));

    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    sat_l_d   = sat_l_q;
    sat_r_d   = sat_r_q;
    clip_l_d  = clip_l_q;
    clip_r_d  = clip_r_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    valid_d   = 1'b0;
    clip_d    = 1'b0;
    // A toggle outside IDLE is dropped; the running mix continues untouched.
    overrun_d = toggle && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (toggle) begin
          if (LATCH_DELAY == 0) begin
            state_d = S_ACCUM;
            idx_d   = '0;
            acc_l_d = '0;
            acc_r_d = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATCH_DELAY);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Leaving on the count-to-zero cycle gives exactly LATCH_DELAY waits.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_ACCUM;
          idx_d   = '0;
          acc_l_d = '0;
          acc_r_d = '0;
        end
      end
      S_ACCUM: begin
        acc_l_d = acc_l_q + scale(ACC_W'(ch_l), ch_vol);
        acc_r_d = acc_r_q + scale(ACC_W'(ch_r), ch_vol);
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(CHANNELS - 1)) state_d = S_MASTER;
      end
      S_MASTER: begin
        sat_l_d  = res_l[15:0];
        clip_l_d = res_l[16];
        sat_r_d  = res_r[15:0];
        clip_r_d = res_r[16];
        state_d  = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_l_d = sat_l_q;
        out_r_d = sat_r_q;
        valid_d = 1'b1;
        clip_d  = clip_l_q | clip_r_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      last_clk_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      sat_l_q    <= '0;
      sat_r_q    <= '0;
      clip_l_q   <= 1'b0;
      clip_r_q   <= 1'b0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_clk_q <= i_output_sample_clock;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      sat_l_q    <= sat_l_d;
      sat_r_q    <= sat_r_d;
      clip_l_q   <= clip_l_d;
      clip_r_q   <= clip_r_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_sample_left  = out_l_q;
  assign o_sample_right = out_r_q;
  assign o_sample_valid = valid_q;
  assign o_clip         = clip_q;
  assign o_overrun      = overrun_q;

`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  logic [15:0] clip_cnt_q;

  // Clear wins over a coincident increment; the count sticks at 0xFFFF.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                              clip_cnt_q <= '0;
    else if (i_clip_count_clear)              clip_cnt_q <= '0;
    else if (clip_q && clip_cnt_q != 16'hFFFF) clip_cnt_q <= clip_cnt_q + 16'd1;
  end

  assign o_clip_count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// tb/tb_audio_mixer.sv - scoreboard bench for audio_mixer
module tb_audio_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic [63:0] ch_l = '0;
  logic [63:0] ch_r = '0;
  logic [15:0] ch_v = '0;
  logic [3:0]  mvol = 4'd15;
  logic [15:0] o_l, o_r;
  logic        o_valid, o_clip, o_overrun;
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  logic        cc_clear = 1'b0;
  logic [15:0] cc_count;
`endif

  audio_mixer #(.CHANNELS(4), .LATCH_DELAY(3)) dut (
    .i_clock               (clk),
    .i_reset               (rst),
    .i_output_sample_clock (sclk),
    .i_channel_left        (ch_l),
    .i_channel_right       (ch_r),
    .i_channel_volume      (ch_v),
    .i_master_volume       (mvol),
    .o_sample_left         (o_l),
    .o_sample_right        (o_r),
    .o_sample_valid        (o_valid),
    .o_clip                (o_clip),
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
    .i_clip_count_clear    (cc_clear),
    .o_clip_count          (cc_count),
`endif
    .o_overrun             (o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        c;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("left", {16'h0, o_l}, {16'h0, e.l});
        check("right", {16'h0, o_r}, {16'h0, e.r});
        check("clip", {31'h0, o_clip}, {31'h0, e.c});
        check("latency", cyc, e.due);
      end
    end
  end

  // Sets inputs and toggles the sample clock; the next edge detects it.
  task automatic start_mix(input logic [63:0] l, input logic [63:0] r, input logic [15:0] v,
                           input logic [3:0] m, input logic [15:0] el, input logic [15:0] er,
                           input logic ec, output int det);
    exp_t e;
    @(negedge clk);
    ch_l = l;
    ch_r = r;
    ch_v = v;
    mvol = m;
    sclk = ~sclk;
    det  = cyc + 1;
    e.l = el; e.r = er; e.c = ec; e.due = det + 9;
    exp_q.push_back(e);
  endtask

  task automatic mix(input logic [63:0] l, input logic [63:0] r, input logic [15:0] v,
                     input logic [3:0] m, input logic [15:0] el, input logic [15:0] er,
                     input logic ec);
    int det;
    start_mix(l, r, v, m, el, er, ec, det);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int det;

    repeat (2) @(negedge clk);
    check("rst_left", {16'h0, o_l}, 32'h0);
    check("rst_right", {16'h0, o_r}, 32'h0);
    check("rst_valid", {31'h0, o_valid}, 32'h0);
    check("rst_overrun", {31'h0, o_overrun}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unity on ch0; other channels carry data but are muted.
    mix({16'h1234, 16'h5678, 16'h7FFF, 16'h4000}, {16'h1111, 16'h2222, 16'h3333, 16'hC000},
        16'h000F, 4'd15, 16'h4000, 16'hC000, 1'b0);
    mix({48'h0, 16'h4000}, {48'h0, 16'hFFFF}, 16'h0008, 4'd15, 16'h2000, 16'hFFFF, 1'b0);
    mix({48'h0, 16'hFFFF}, {48'h0, 16'h0010}, 16'h0001, 4'd15, 16'hFFFF, 16'h0001, 1'b0);
    mix({48'h0, 16'h4000}, {48'h0, 16'hC000}, 16'h000F, 4'd0, 16'h0000, 16'h0000, 1'b0);
    mix({4{16'h7000}}, {4{16'h9000}}, 16'hFFFF, 4'd15, 16'h7FFF, 16'h8000, 1'b1);
    mix({4{16'h7000}}, {4{16'h9000}}, 16'hFFFF, 4'd4, 16'h7000, 16'h9000, 1'b0);
    // 0x1000 + 0x1000 + 0x40 - 0x1000 = 0x1040, then *8/16 = 0x820.
    mix({16'h8000, 16'h0100, 16'h2000, 16'h1000}, 64'h0, 16'h248F, 4'd8,
        16'h0820, 16'h0000, 1'b0);

    // Second toggle 4 cycles into a mix is dropped with one overrun pulse.
    start_mix({48'h0, 16'h4000}, {48'h0, 16'hC000}, 16'h000F, 4'd15,
              16'h4000, 16'hC000, 1'b0, det);
    repeat (3) @(negedge clk);
    sclk = ~sclk;
    @(negedge clk);
    check("overrun_pulse", {31'h0, o_overrun}, 32'h1);
    @(negedge clk);
    check("overrun_single", {31'h0, o_overrun}, 32'h0);
    repeat (10) @(negedge clk);

    // Reset at edge 5 of a mix: outputs clear at once, no valid for that mix.
    @(negedge clk);
    ch_l = {48'h0, 16'h7777};
    ch_v = 16'h000F;
    sclk = ~sclk;
    det  = cyc + 1;
    while (cyc < det + 4) @(negedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    sclk = 1'b0;
    #1;
    check("midrst_left", {16'h0, o_l}, 32'h0);
    check("midrst_right", {16'h0, o_r}, 32'h0);
    check("midrst_valid", {30'h0, o_valid, o_clip}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mix({48'h0, 16'h4000}, {48'h0, 16'hFFFF}, 16'h0008, 4'd15, 16'h2000, 16'hFFFF, 1'b0);

`ifdef AUDIO_MIXER_CLIP_COUNT_EN
    repeat (3) mix({4{16'h7000}}, {4{16'h9000}}, 16'hFFFF, 4'd15, 16'h7FFF, 16'h8000, 1'b1);
    check("clip_count_3", {16'h0, cc_count}, 32'd3);
    start_mix({4{16'h7000}}, {4{16'h9000}}, 16'hFFFF, 4'd15, 16'h7FFF, 16'h8000, 1'b1, det);
    while (cyc < det + 9) @(negedge clk);
    cc_clear = 1'b1;
    @(negedge clk);
    cc_clear = 1'b0;
    check("clip_count_clear", {16'h0, cc_count}, 32'd0);
    repeat (4) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    check("pending_results", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
